// File: rtl/attack_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : attack_frame_rx
// Purpose  : Assembles 4-byte attack frames (0xA5, move_id, damage, checksum)
//            from a byte-wide serial receiver, verifies the checksum and holds
//            the frame until the consumer acknowledges it. Reports checksum,
//            inter-byte timeout and overrun errors as one-cycle pulses plus a
//            saturating error counter.
// Ports    : clk           - system clock (only clock)
//            reset_n       - asynchronous active-low reset
//            rx_byte       - byte from the serial receiver
//            char_received - level-held byte-ready flag (rising edge = byte)
//            frame_ack     - consumer acknowledge releasing a held frame
//            frame_valid   - verified frame is being held
//            move_id       - move byte of the held frame
//            damage        - damage byte of the held frame
//            sum_err       - one-cycle pulse, checksum mismatch
//            timeout_err   - one-cycle pulse, inter-byte timeout
//            overrun_err   - one-cycle pulse, good frame dropped (not acked)
//            err_count     - total errors, saturating at 255
//            busy          - FSM is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module attack_frame_rx #(
  parameter int unsigned TIMEOUT_CYC = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       char_received,
  input  logic       frame_ack,
  output logic       frame_valid,
  output logic [7:0] move_id,
  output logic [7:0] damage,
  output logic       sum_err,
  output logic       timeout_err,
  output logic       overrun_err,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] C_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_MOVE = 2'd1,
    GET_DMG  = 2'd2,
    GET_SUM  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_char_prev;
  logic             r_armed;
  logic [7:0]       r_move;
  logic [7:0]       r_dmg;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_frame_valid;
  logic [7:0]       r_move_id;
  logic [7:0]       r_damage;
  logic             r_sum_err;
  logic             r_timeout_err;
  logic             r_overrun_err;
  logic [7:0]       r_err_count;

  logic       w_capture;
  logic       w_in_sum;
  logic [7:0] w_sum;
  logic       w_sum_bad;
  logic       w_ovr;
  logic       w_load;
  logic       w_to;
  logic       w_err;

  // r_armed stays low after reset until char_received has been seen low, so a
  // flag already high at reset release is never taken as a fresh edge.
  assign w_capture = char_received & ~r_char_prev & r_armed;
  assign w_in_sum  = w_capture && (r_state == GET_SUM);
  assign w_sum     = r_move + r_dmg;
  assign w_sum_bad = w_in_sum && (rx_byte != w_sum);
  // An acknowledge in the same cycle frees the holding slot, so no overrun.
  assign w_ovr     = w_in_sum && !w_sum_bad && r_frame_valid && !frame_ack;
  assign w_load    = w_in_sum && !w_sum_bad && !w_ovr;
  // A capture in the same cycle takes priority over the timeout.
  assign w_to      = !w_capture && (r_state != IDLE) && (r_to_cnt == C_TO_LAST);
  // The three error sources are mutually exclusive by construction.
  assign w_err     = w_sum_bad | w_ovr | w_to;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_char_prev   <= 1'b0;
      r_armed       <= 1'b0;
      r_move        <= 8'h00;
      r_dmg         <= 8'h00;
      r_to_cnt      <= '0;
      r_frame_valid <= 1'b0;
      r_move_id     <= 8'h00;
      r_damage      <= 8'h00;
      r_sum_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
      r_err_count   <= 8'h00;
    end else begin
      r_char_prev   <= char_received;
      r_armed       <= r_armed | ~char_received;
      r_sum_err     <= w_sum_bad;
      r_overrun_err <= w_ovr;
      r_timeout_err <= w_to;

      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end

      if (w_load) begin
        r_move_id     <= r_move;
        r_damage      <= r_dmg;
        r_frame_valid <= 1'b1;
      end else if (r_frame_valid && frame_ack) begin
        r_frame_valid <= 1'b0;
      end

      if (w_capture) begin
        r_to_cnt <= '0;
        case (r_state)
          IDLE: begin
            if (rx_byte == C_HEADER) begin
              r_state <= GET_MOVE;
            end
          end
          GET_MOVE: begin
            r_move  <= rx_byte;
            r_state <= GET_DMG;
          end
          GET_DMG: begin
            r_dmg   <= rx_byte;
            r_state <= GET_SUM;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end else if (r_state == IDLE) begin
        r_to_cnt <= '0;
      end else if (w_to) begin
        r_state  <= IDLE;
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + CNT_W'(1);
      end
    end
  end

  assign frame_valid = r_frame_valid;
  assign move_id     = r_move_id;
  assign damage      = r_damage;
  assign sum_err     = r_sum_err;
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;
  assign err_count   = r_err_count;
  assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire
